// File: rtl/irq_ctrl.sv
// Interrupt aggregator: edge-detects sources into pending bits, masks them and
// drives one registered active-low interrupt line. CSR window is five registers.
module irq_ctrl #(
    parameter logic [4:0] BASE_ADDR = 5'h0,
    parameter int         NUM_SRC   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         csr_a,
    input  logic [7:0]         csr_di,
    input  logic               csr_we,
    output logic [7:0]         csr_do,
    input  logic [NUM_SRC-1:0] src,
    output logic               irq_n
);

    logic [NUM_SRC-1:0] ie_q, ie_d;
    logic [NUM_SRC-1:0] ip_q, ip_d;
    logic [NUM_SRC-1:0] ovf_q, ovf_d;
    logic [NUM_SRC-1:0] src_q, src_d;
    logic               gen_q, gen_d;
    logic               irq_n_q, irq_n_d;

    logic [4:0]         off;
    logic               in_win;
    logic [NUM_SRC-1:0] ev, clr_ip, clr_ovf;
    logic [7:0]         ie_rd, ip_rd, ovf_rd, src_rd;

    // Offset arithmetic wraps in 5 bits so a window near the top of the map still decodes.
    assign off    = csr_a - BASE_ADDR;
    assign in_win = (off < 5'd5);
    assign ev     = src & ~src_q;

    always_comb begin
        clr_ip  = '0;
        clr_ovf = '0;
        ie_d    = ie_q;
        gen_d   = gen_q;
        if (csr_we && in_win) begin
            case (off)
                5'd0:    ie_d    = csr_di[NUM_SRC-1:0];
                5'd1:    clr_ip  = csr_di[NUM_SRC-1:0];
                5'd2:    clr_ovf = csr_di[NUM_SRC-1:0];
                5'd3:    gen_d   = csr_di[0];
                default: ;
            endcase
        end
        // A new edge always wins over a clear; a lost event only counts if not cleared now.
        ip_d    = ev | (ip_q & ~clr_ip);
        ovf_d   = (ev & ip_q & ~clr_ip) | (ovf_q & ~clr_ovf);
        src_d   = src;
        irq_n_d = ~(gen_q & |(ip_q & ie_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie_q    <= '0;
            ip_q    <= '0;
            ovf_q   <= '0;
            src_q   <= '0;
            gen_q   <= 1'b0;
            irq_n_q <= 1'b1;
        end else begin
            ie_q    <= ie_d;
            ip_q    <= ip_d;
            ovf_q   <= ovf_d;
            src_q   <= src_d;
            gen_q   <= gen_d;
            irq_n_q <= irq_n_d;
        end
    end

    always_comb begin
        ie_rd  = '0;
        ip_rd  = '0;
        ovf_rd = '0;
        src_rd = '0;
        ie_rd[NUM_SRC-1:0]  = ie_q;
        ip_rd[NUM_SRC-1:0]  = ip_q;
        ovf_rd[NUM_SRC-1:0] = ovf_q;
        src_rd[NUM_SRC-1:0] = src_q;
        csr_do = '0;
        if (in_win) begin
            case (off)
                5'd0:    csr_do = ie_rd;
                5'd1:    csr_do = ip_rd;
                5'd2:    csr_do = ovf_rd;
                5'd3:    csr_do = {~irq_n_q, 6'b0, gen_q};
                5'd4:    csr_do = src_rd;
                default: csr_do = '0;
            endcase
        end
    end

    assign irq_n = irq_n_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed vector bench for irq_ctrl: an 8-source instance driven from a table,
// plus a 4-source instance exercising width truncation and reset while asserted.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    logic [7:0] src;
    logic       irq_n;

    logic       rst4_n;
    logic [4:0] csr4_a;
    logic [7:0] csr4_di;
    logic       csr4_we;
    logic [7:0] csr4_do;
    logic [3:0] src4;
    logic       irq4_n;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.BASE_ADDR(5'h0), .NUM_SRC(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(csr_do), .src(src), .irq_n(irq_n)
    );

    irq_ctrl #(.BASE_ADDR(5'h0), .NUM_SRC(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .csr_a(csr4_a), .csr_di(csr4_di), .csr_we(csr4_we),
        .csr_do(csr4_do), .src(src4), .irq_n(irq4_n)
    );

    typedef struct {
        logic       we;
        logic [4:0] a;
        logic [7:0] di;
        logic [7:0] src;
        logic [7:0] exp_do;
        logic       exp_irq_n;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic we, input logic [4:0] a, input logic [7:0] di,
                       input logic [7:0] s, input logic [7:0] e_do, input logic e_irq);
        vec_t v;
        v.we = we; v.a = a; v.di = di; v.src = s; v.exp_do = e_do; v.exp_irq_n = e_irq;
        tv.push_back(v);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; csr_a = '0; csr_di = '0; csr_we = 1'b0; src = '0;
        rst4_n = 1'b0; csr4_a = '0; csr4_di = '0; csr4_we = 1'b0; src4 = '0;

        // Each row: inputs held for one cycle, outputs checked before that cycle's edge.
        //  we  a     di     src    do     irq_n
        add(0, 5'd0, 8'h00, 8'h00, 8'h00, 1); // 0 reset reads
        add(0, 5'd1, 8'h00, 8'h00, 8'h00, 1);
        add(0, 5'd2, 8'h00, 8'h00, 8'h00, 1);
        add(0, 5'd3, 8'h00, 8'h00, 8'h00, 1);
        add(0, 5'd4, 8'h00, 8'h00, 8'h00, 1);
        add(0, 5'd5, 8'h00, 8'h00, 8'h00, 1); // 5 outside window
        add(1, 5'd0, 8'h01, 8'h00, 8'h00, 1); // IE=01
        add(1, 5'd3, 8'h01, 8'h00, 8'h00, 1); // GEN=1
        add(0, 5'd0, 8'h00, 8'h01, 8'h01, 1); // 8 pulse src[0]
        add(0, 5'd1, 8'h00, 8'h00, 8'h01, 1); // ip set, irq_n not yet low
        add(0, 5'd3, 8'h00, 8'h00, 8'h81, 0); // 10 irq_n low 2 edges after pulse
        add(1, 5'd1, 8'h01, 8'h00, 8'h01, 0); // W1C ip[0]
        add(0, 5'd1, 8'h00, 8'h00, 8'h00, 0); // ip gone, irq_n one cycle behind
        add(0, 5'd1, 8'h00, 8'h08, 8'h00, 1); // pulse src[3], masked
        add(0, 5'd1, 8'h00, 8'h00, 8'h08, 1);
        add(0, 5'd3, 8'h00, 8'h00, 8'h01, 1); // 15 stays deasserted
        add(1, 5'd1, 8'hFF, 8'h00, 8'h08, 1); // clear all
        add(1, 5'd0, 8'h04, 8'h00, 8'h01, 1); // IE=04
        add(0, 5'd1, 8'h00, 8'h04, 8'h00, 1); // 18 src[2] held 10 cycles
        add(0, 5'd1, 8'h00, 8'h04, 8'h04, 1);
        for (int i = 0; i < 8; i++) add(0, 5'd1, 8'h00, 8'h04, 8'h04, 0);
        add(0, 5'd2, 8'h00, 8'h00, 8'h00, 0); // 28 no overflow from a level
        add(0, 5'd1, 8'h00, 8'h04, 8'h04, 0); // second pulse while pending
        add(0, 5'd2, 8'h00, 8'h00, 8'h04, 0); // 30 overflow recorded
        add(1, 5'd2, 8'h04, 8'h00, 8'h04, 0); // W1C OVF
        add(0, 5'd2, 8'h00, 8'h00, 8'h00, 0);
        add(0, 5'd4, 8'h00, 8'h0A, 8'h00, 0); // SRC shows src_q
        add(0, 5'd4, 8'h00, 8'h0A, 8'h0A, 0);
        add(0, 5'd1, 8'h00, 8'h00, 8'h0E, 0); // 35
        add(1, 5'd1, 8'h02, 8'h02, 8'h0E, 0); // event + W1C same cycle on bit1
        add(0, 5'd1, 8'h00, 8'h00, 8'h0E, 0); // ip[1] kept
        add(0, 5'd2, 8'h00, 8'h00, 8'h00, 0); // no overflow
        add(1, 5'd2, 8'h02, 8'h02, 8'h00, 0); // overflow set vs OVF W1C: set wins
        add(0, 5'd2, 8'h00, 8'h00, 8'h02, 0); // 40
        add(1, 5'd3, 8'h00, 8'h00, 8'h81, 0); // GEN=0
        add(0, 5'd3, 8'h00, 8'h00, 8'h80, 0); // irq_n one cycle behind
        add(0, 5'd3, 8'h00, 8'h00, 8'h00, 1);
        add(1, 5'd4, 8'hFF, 8'h00, 8'h00, 1); // SRC is read-only
        add(0, 5'd0, 8'h00, 8'h00, 8'h04, 1); // 45 IE untouched
        add(1, 5'd7, 8'hFF, 8'h00, 8'h00, 1); // write outside window
        add(0, 5'd0, 8'h00, 8'h00, 8'h04, 1);
        add(0, 5'd1, 8'h00, 8'h00, 8'h0E, 1);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; rst4_n = 1'b1;

        foreach (tv[i]) begin
            csr_we = tv[i].we; csr_a = tv[i].a; csr_di = tv[i].di; src = tv[i].src;
            #4;
            chk8($sformatf("v%0d csr_do", i), csr_do, tv[i].exp_do);
            chk8($sformatf("v%0d irq_n", i), {7'b0, irq_n}, {7'b0, tv[i].exp_irq_n});
            @(posedge clk); #1;
        end
        csr_we = 1'b0; src = '0;

        // Narrow instance: upper bits dropped on write and read back as zero.
        csr4_we = 1'b1; csr4_a = 5'd0; csr4_di = 8'hFF;
        @(posedge clk); #1;
        csr4_a = 5'd3; csr4_di = 8'h01;
        @(posedge clk); #1;
        csr4_we = 1'b0; csr4_a = 5'd0; src4 = 4'h8;
        #4 chk8("n4 ie", csr4_do, 8'h0F);
        @(posedge clk); #1;
        src4 = 4'h0;
        for (int k = 0; k < 10 && irq4_n; k++) begin
            @(posedge clk); #1;
        end
        chk8("n4 irq_n asserted", {7'b0, irq4_n}, 8'h00);
        csr4_a = 5'd1;
        #1 chk8("n4 ip", csr4_do, 8'h08);

        // Reset while the line is asserted discards everything on the next edge.
        rst4_n = 1'b0;
        @(posedge clk); #1;
        chk8("n4 rst irq_n", {7'b0, irq4_n}, 8'h01);
        for (int r = 0; r < 5; r++) begin
            csr4_a = 5'(r);
            #1 chk8($sformatf("n4 rst reg%0d", r), csr4_do, 8'h00);
        end
        rst4_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
